// File: rtl/chess_pkg.sv
// rtl/chess_pkg.sv - shared piece encoding, register map and scheduler states
package chess_pkg;

  typedef enum logic [2:0] {
    PAWN   = 3'd0,
    ROOK   = 3'd1,
    KNIGHT = 3'd2,
    BISHOP = 3'd3,
    QUEEN  = 3'd4,
    KING   = 3'd5
  } piece_t;

  // Lower bound of each piece's magnitude band; the king is a single value
  localparam logic [7:0] PAWN_MIN   = 8'd1;
  localparam logic [7:0] ROOK_MIN   = 8'd9;
  localparam logic [7:0] KNIGHT_MIN = 8'd19;
  localparam logic [7:0] BISHOP_MIN = 8'd29;
  localparam logic [7:0] QUEEN_MIN  = 8'd39;
  localparam logic [7:0] KING_VAL   = 8'd48;

  localparam logic [3:0] REG_CTRL   = 4'd0;
  localparam logic [3:0] REG_BOARD  = 4'd1;
  localparam logic [3:0] REG_DEST   = 4'd2;
  localparam logic [3:0] REG_COLOUR = 4'd3;

  localparam logic [3:0] GEN_REG_CTRL  = 4'd0;
  localparam logic [3:0] GEN_REG_BOARD = 4'd1;
  localparam logic [3:0] GEN_REG_DEST  = 4'd2;
  localparam logic [3:0] GEN_REG_X     = 4'd3;
  localparam logic [3:0] GEN_REG_Y     = 4'd4;

  localparam int BOARD_SQUARES = 64;

  typedef enum logic [3:0] {
    S_IDLE, S_RD_REQ, S_RD_WAIT, S_DECODE,
    S_G_BOARD, S_G_DEST, S_G_X, S_G_Y, S_G_START, S_G_POLL,
    S_ACCUM, S_NEXT, S_DONE
  } state_t;

endpackage

// File: rtl/piece_decode.sv
// rtl/piece_decode.sv - classifies a signed square byte into ownership and generator
module piece_decode
  import chess_pkg::*;
(
  input  logic [7:0] square,
  input  logic       colour,
  output logic       own,
  output piece_t     sel
);

  logic [7:0] mag;

  always_comb begin
    mag = square[7] ? (~square + 8'd1) : square;
    sel = PAWN;
    if (mag >= KING_VAL)        sel = KING;
    else if (mag >= QUEEN_MIN)  sel = QUEEN;
    else if (mag >= BISHOP_MIN) sel = BISHOP;
    else if (mag >= KNIGHT_MIN) sel = KNIGHT;
    else if (mag >= ROOK_MIN)   sel = ROOK;
    // -128 negates to itself and falls out through the magnitude bound
    own = (square != 8'd0) && (mag <= KING_VAL) && (square[7] == colour);
  end

endmodule

// File: rtl/move_gen_scheduler.sv
// rtl/move_gen_scheduler.sv - walks the board and dispatches each own piece to its move generator
module move_gen_scheduler
  import chess_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        slave_waitrequest,
  input  logic [3:0]  slave_address,
  input  logic        slave_read,
  output logic [31:0] slave_readdata,
  input  logic        slave_write,
  input  logic [31:0] slave_writedata,
  input  logic        master_waitrequest,
  output logic [31:0] master_address,
  output logic        master_read,
  input  logic [31:0] master_readdata,
  input  logic        master_readdatavalid,
  output logic [2:0]  gen_sel,
  input  logic        gen_waitrequest,
  output logic [3:0]  gen_address,
  output logic        gen_read,
  input  logic [31:0] gen_readdata,
  output logic        gen_write,
  output logic [31:0] gen_writedata
);

  state_t           state, state_next;
  logic [31:0]      board_addr, dest_reg, dest_ptr;
  logic             colour;
  logic [5:0]       idx;
  logic [CNT_W-1:0] total, n_r;
  piece_t           sel_r;
  logic             own_r;
  logic             dec_own;
  piece_t           dec_sel;
  logic             busy;
  logic             unused_bits;

  assign unused_bits = ^{master_readdata[31:8], gen_readdata[31:CNT_W]};
  assign gen_sel     = sel_r;
  assign busy        = (state != S_IDLE) && (state != S_DONE);

  piece_decode u_decode (
    .square (master_readdata[7:0]),
    .colour (colour),
    .own    (dec_own),
    .sel    (dec_sel)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Bus strobes are pure functions of state so a reset drops them immediately
  always_comb begin
    state_next        = state;
    master_read       = 1'b0;
    master_address    = 32'd0;
    gen_write         = 1'b0;
    gen_read          = 1'b0;
    gen_address       = 4'd0;
    gen_writedata     = 32'd0;
    slave_waitrequest = slave_read && (slave_address == REG_CTRL) && busy;
    case (state)
      S_IDLE: if (slave_write && slave_address == REG_CTRL) state_next = S_RD_REQ;
      S_RD_REQ: begin
        master_read    = 1'b1;
        master_address = board_addr + {26'd0, idx};
        if (!master_waitrequest) state_next = S_RD_WAIT;
      end
      S_RD_WAIT: if (master_readdatavalid) state_next = S_DECODE;
      S_DECODE:  state_next = own_r ? S_G_BOARD : S_NEXT;
      S_G_BOARD: begin
        gen_write     = 1'b1;
        gen_address   = GEN_REG_BOARD;
        gen_writedata = board_addr;
        if (!gen_waitrequest) state_next = S_G_DEST;
      end
      S_G_DEST: begin
        gen_write     = 1'b1;
        gen_address   = GEN_REG_DEST;
        gen_writedata = dest_ptr;
        if (!gen_waitrequest) state_next = S_G_X;
      end
      S_G_X: begin
        gen_write     = 1'b1;
        gen_address   = GEN_REG_X;
        gen_writedata = {29'd0, idx[2:0]};
        if (!gen_waitrequest) state_next = S_G_Y;
      end
      S_G_Y: begin
        gen_write     = 1'b1;
        gen_address   = GEN_REG_Y;
        gen_writedata = {29'd0, idx[5:3]};
        if (!gen_waitrequest) state_next = S_G_START;
      end
      S_G_START: begin
        gen_write   = 1'b1;
        gen_address = GEN_REG_CTRL;
        if (!gen_waitrequest) state_next = S_G_POLL;
      end
      S_G_POLL: begin
        gen_read    = 1'b1;
        gen_address = GEN_REG_CTRL;
        if (!gen_waitrequest) state_next = S_ACCUM;
      end
      S_ACCUM: state_next = S_NEXT;
      S_NEXT:  state_next = (idx == 6'd63) ? S_DONE : S_RD_REQ;
      S_DONE:  if (slave_read && slave_address == REG_CTRL) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    slave_readdata = 32'd0;
    if (slave_read) begin
      case (slave_address)
        REG_CTRL:   slave_readdata = 32'(total);
        REG_BOARD:  slave_readdata = board_addr;
        REG_DEST:   slave_readdata = dest_reg;
        REG_COLOUR: slave_readdata = {31'd0, colour};
        default:    slave_readdata = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      board_addr <= 32'd0;
      dest_reg   <= 32'd0;
      dest_ptr   <= 32'd0;
      colour     <= 1'b0;
      idx        <= 6'd0;
      total      <= '0;
      n_r        <= '0;
      sel_r      <= PAWN;
      own_r      <= 1'b0;
    end else begin
      if (state == S_IDLE && slave_write) begin
        case (slave_address)
          REG_BOARD:  board_addr <= slave_writedata;
          REG_DEST:   dest_reg   <= slave_writedata;
          REG_COLOUR: colour     <= slave_writedata[0];
          REG_CTRL: begin
            dest_ptr <= dest_reg;
            idx      <= 6'd0;
            total    <= '0;
          end
          default: ;
        endcase
      end
      // gen_sel only moves on a dispatch so it is steady for the whole sequence
      if (state == S_RD_WAIT && master_readdatavalid) begin
        own_r <= dec_own;
        if (dec_own) sel_r <= dec_sel;
      end
      if (state == S_G_POLL && !gen_waitrequest) n_r <= gen_readdata[CNT_W-1:0];
      if (state == S_ACCUM) begin
        dest_ptr <= dest_ptr + (32'(n_r) << 6);
        total    <= total + n_r;
      end
      if (state == S_NEXT && idx != 6'd63) idx <= idx + 6'd1;
    end
  end

endmodule
